stream2mmap_hs_responder: RTL and testbench



---
 rtl/stream2mmap_hs_responder_if.sv | 31 +++
 rtl/stream2mmap_hs_responder.sv | 164 ++++++++++++++++
 tb/tb_stream2mmap_hs_responder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream2mmap_hs_responder_if.sv
// Handshake and data bus for the Stream2Mmap ap_ctrl_hs responder.
// The master side is the initiator/stream source/memory; the slave side is the responder.
interface stream2mmap_hs_responder_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_done;
    logic                  ap_idle;
    logic [63:0]           mmap;
    logic [63:0]           n;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [63:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_ack;
    logic                  err;

    modport slave (
        input  ap_start, mmap, n, in_data, in_valid, wr_ready, wr_ack,
        output ap_ready, ap_done, ap_idle, in_ready, wr_addr, wr_data, wr_valid, err
    );

    modport master (
        output ap_start, mmap, n, in_data, in_valid, wr_ready, wr_ack,
        input  ap_ready, ap_done, ap_idle, in_ready, wr_addr, wr_data, wr_valid, err
    );
endinterface

// File: rtl/stream2mmap_hs_responder.sv
// ap_ctrl_hs task responder: streams n words into consecutive memory writes, then pulses ap_done.
// Optional outstanding-write cap enabled by defining S2M_OUTSTANDING_LIMIT_EN.
module stream2mmap_hs_responder #(
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    stream2mmap_hs_responder_if.slave bus
);
    localparam logic [63:0] BYTES_PER_WORD = 64'(DATA_WIDTH / 8);

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $error("DATA_WIDTH must be a positive multiple of 8");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 65536) begin : g_bad_cap
            $error("MAX_OUTSTANDING must lie in 1..65536");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [63:0]           total_q,     total_d;
    logic [63:0]           issued_q,    issued_d;
    logic [63:0]           acked_q,     acked_d;
    logic [63:0]           next_addr_q, next_addr_d;
    logic [63:0]           wr_addr_q,   wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic                  wr_valid_q,  wr_valid_d;
    logic                  err_q,       err_d;

    logic [63:0] in_flight;
    logic        cap_ok;
    logic        in_ready;
    logic        in_fire;
    logic        wr_fire;
    logic        ack_ok;

    // Writes that left the output register but are not yet acknowledged.
    assign in_flight = issued_q - acked_q - {63'd0, wr_valid_q};

`ifdef S2M_OUTSTANDING_LIMIT_EN
    // The word parked in the output register already counts against the cap.
    assign cap_ok = (issued_q - acked_q) < 64'(MAX_OUTSTANDING);
`else
    assign cap_ok = 1'b1;
`endif

    assign in_ready = (state_q == RUN) && (issued_q < total_q)
                   && (!wr_valid_q || bus.wr_ready) && cap_ok;
    assign in_fire  = in_ready && bus.in_valid;
    assign wr_fire  = wr_valid_q && bus.wr_ready;
    assign ack_ok   = (state_q == RUN) && (in_flight != 64'd0);

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        issued_d    = issued_q;
        acked_d     = acked_q;
        next_addr_d = next_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = wr_valid_q;
        err_d       = err_q;

        if (bus.wr_ack) begin
            if (ack_ok) begin
                acked_d = acked_q + 64'd1;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.ap_start) begin
                    next_addr_d = bus.mmap;
                    total_d     = bus.n;
                    issued_d    = 64'd0;
                    acked_d     = 64'd0;
                    err_d       = 1'b0;
                    wr_valid_d  = 1'b0;
                    state_d     = (bus.n == 64'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_fire) begin
                    wr_data_d   = bus.in_data;
                    wr_addr_d   = next_addr_q;
                    next_addr_d = next_addr_q + BYTES_PER_WORD;
                    wr_valid_d  = 1'b1;
                    issued_d    = issued_q + 64'd1;
                end else if (wr_fire) begin
                    wr_valid_d = 1'b0;
                end
                // acked can only reach total once every word was written and acknowledged.
                if (acked_q == total_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            total_q     <= 64'd0;
            issued_q    <= 64'd0;
            acked_q     <= 64'd0;
            next_addr_q <= 64'd0;
            wr_addr_q   <= 64'd0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            acked_q     <= acked_d;
            next_addr_q <= next_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.ap_idle  = (state_q == IDLE);
    assign bus.ap_ready = (state_q == IDLE) && bus.ap_start;
    assign bus.ap_done  = (state_q == DONE);
    assign bus.in_ready = in_ready;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.err      = err_q;

`ifndef SYNTHESIS
    a_wr_hold: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (bus.wr_valid && !bus.wr_ready) |=>
            (bus.wr_valid && $stable(bus.wr_addr) && $stable(bus.wr_data)));

    a_counter_order: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (acked_q <= issued_q) && (issued_q <= total_q));

    a_done_not_ready: assert property (@(posedge ap_clk) disable iff (ap_rst)
        bus.ap_done |-> !bus.ap_ready);
`ifdef S2M_OUTSTANDING_LIMIT_EN
    a_cap: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (issued_q - acked_q) <= 64'(MAX_OUTSTANDING));
`endif
`endif
endmodule

// File: tb/tb_stream2mmap_hs_responder.sv
// Scenario bench for stream2mmap_hs_responder: a monitor pushes expected writes on input
// handshakes and observed writes on write handshakes; each scenario task compares them.
module tb_stream2mmap_hs_responder;
    localparam int DW   = 64;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream2mmap_hs_responder_if #(.DATA_WIDTH(DW)) bus();

    stream2mmap_hs_responder #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [63:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  errors = 0;
    int  checks = 0;
    int  sb_rd  = 0;
    int  cyc    = 0;
    logic auto_ack = 1'b0;
    logic man_ack  = 1'b0;

    // monitor-owned state
    int          pending  = 0;
    int          widx     = 0;
    int          writes   = 0;
    int          first_wr = 0;
    int          last_wr  = 0;
    int          last_ack = 0;
    logic        took     = 1'b0;
    logic [63:0] exp_base = 64'd0;
    logic [63:0] exp_word = 64'd0;
    wr_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Source, ack generator and scoreboard feeder; acts 1-2 time units after each falling edge.
    always @(negedge clk) begin
        #1;
        if (took) begin
            widx = widx + 1;
            took = 1'b0;
        end
        bus.in_data = 64'hD00D_0000_0000_0000 + 64'(widx) * 64'h0000_0001_0000_0101;
        if (auto_ack && pending > 0) begin
            bus.wr_ack = 1'b1;
            pending    = pending - 1;
            last_ack   = cyc;
        end else begin
            bus.wr_ack = man_ack;
            if (man_ack) last_ack = cyc;
        end
        #1;
        if (rst) begin
            pending = 0;
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end else begin
            if (bus.ap_ready) begin
                exp_base = bus.mmap;
                exp_word = 64'd0;
                writes   = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e.addr = exp_base + exp_word * 64'(DW / 8);
                mon_e.data = bus.in_data;
                exp_q.push_back(mon_e);
                exp_word = exp_word + 64'd1;
                took     = 1'b1;
            end
            if (bus.wr_valid && bus.wr_ready) begin
                mon_e.addr = bus.wr_addr;
                mon_e.data = bus.wr_data;
                obs_q.push_back(mon_e);
                if (writes == 0) first_wr = cyc;
                last_wr = cyc;
                writes  = writes + 1;
                pending = pending + 1;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.ap_start = 1'b0; bus.mmap = 64'd0; bus.n = 64'd0;
        bus.in_valid = 1'b0; bus.wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if ({bus.ap_idle, bus.ap_ready, bus.ap_done, bus.in_ready, bus.wr_valid, bus.err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got idle,ready,done,in_ready,wr_valid,err=%b want 100000",
                     {bus.ap_idle, bus.ap_ready, bus.ap_done, bus.in_ready, bus.wr_valid, bus.err});
        end
        checks++;
        if (bus.wr_addr !== 64'd0) begin
            errors++; $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr);
        end
        checks++;
        if (bus.wr_data !== '0) begin
            errors++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data);
        end
    endtask

    task automatic test_basic();
        int done_cnt = 0;
        int rdy_cnt  = 0;
        int done_cyc = 0;
        @(negedge clk);
        bus.mmap = 64'h1000; bus.n = 64'd4; bus.ap_start = 1'b1;
        bus.in_valid = 1'b1; bus.wr_ready = 1'b1; auto_ack = 1'b1;
        #3;
        checks++;
        if ({bus.ap_ready, bus.ap_idle} !== 2'b11) begin
            errors++; $display("FAIL basic_accept: got ready,idle=%b want 11", {bus.ap_ready, bus.ap_idle});
        end
        @(negedge clk);
        bus.ap_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (bus.ap_ready) rdy_cnt++;
            if (bus.ap_done) begin done_cnt++; done_cyc = cyc; end
            if (done_cnt > 0 && bus.ap_idle) break;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (done_cyc - last_ack !== 2) begin
            errors++; $display("FAIL basic_done_latency: got %0d cycles after last ack want 2", done_cyc - last_ack);
        end
        checks++;
        if (writes !== 4 || last_wr - first_wr !== 3) begin
            errors++; $display("FAIL basic_write_burst: got %0d writes over %0d cycles want 4 over 3", writes, last_wr - first_wr);
        end
        checks++;
        if (rdy_cnt !== 0) begin errors++; $display("FAIL basic_ready_after_accept: got %0d want 0", rdy_cnt); end
        while (sb_rd < obs_q.size()) begin
            checks++;
            if (sb_rd >= exp_q.size() || obs_q[sb_rd] !== exp_q[sb_rd]) begin
                errors++;
                $display("FAIL basic_write%0d: got addr=%h data=%h want addr=%h data=%h", sb_rd,
                         obs_q[sb_rd].addr, obs_q[sb_rd].data, exp_q[sb_rd].addr, exp_q[sb_rd].data);
            end
            sb_rd++;
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        bus.mmap = 64'h55; bus.n = 64'd0; bus.ap_start = 1'b1;
        #3;
        checks++;
        if ({bus.ap_ready, bus.ap_done} !== 2'b10) begin
            errors++; $display("FAIL zero_c0: got ready,done=%b want 10", {bus.ap_ready, bus.ap_done});
        end
        @(negedge clk); #3;
        checks++;
        if ({bus.ap_ready, bus.ap_done, bus.ap_idle} !== 3'b010) begin
            errors++; $display("FAIL zero_c1: got ready,done,idle=%b want 010", {bus.ap_ready, bus.ap_done, bus.ap_idle});
        end
        @(negedge clk); #3;
        checks++;
        if ({bus.ap_ready, bus.ap_done, bus.ap_idle} !== 3'b101) begin
            errors++; $display("FAIL zero_c2_reaccept: got ready,done,idle=%b want 101", {bus.ap_ready, bus.ap_done, bus.ap_idle});
        end
        @(negedge clk);
        bus.ap_start = 1'b0;
        #3;
        checks++;
        if ({bus.ap_done, bus.ap_idle} !== 2'b10) begin
            errors++; $display("FAIL zero_c3_done: got done,idle=%b want 10", {bus.ap_done, bus.ap_idle});
        end
        @(negedge clk); #3;
        checks++;
        if ({bus.ap_done, bus.ap_idle, bus.in_ready} !== 3'b010 || writes !== 0) begin
            errors++; $display("FAIL zero_c4_idle: got done,idle,in_ready=%b writes=%0d want 010 writes=0",
                               {bus.ap_done, bus.ap_idle, bus.in_ready}, writes);
        end
    endtask

    task automatic test_addr_wrap();
        int done_cnt = 0;
        @(negedge clk);
        bus.mmap = 64'hFFFF_FFFF_FFFF_FFF8; bus.n = 64'd2; bus.ap_start = 1'b1;
        bus.in_valid = 1'b1; bus.wr_ready = 1'b1; auto_ack = 1'b1;
        @(negedge clk);
        bus.ap_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #3;
            if (bus.ap_done) done_cnt++;
            if (done_cnt > 0 && bus.ap_idle) break;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done_cnt !== 1 || writes !== 2) begin
            errors++; $display("FAIL wrap_complete: got done=%0d writes=%0d want 1 and 2", done_cnt, writes);
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr !== 64'd0) begin
            errors++; $display("FAIL wrap_last_addr: got %h want 0",
                               (obs_q.size() == 0) ? 64'hX : obs_q[obs_q.size()-1].addr);
        end
        while (sb_rd < obs_q.size()) begin
            checks++;
            if (sb_rd >= exp_q.size() || obs_q[sb_rd] !== exp_q[sb_rd]) begin
                errors++;
                $display("FAIL wrap_write%0d: got addr=%h data=%h want addr=%h data=%h", sb_rd,
                         obs_q[sb_rd].addr, obs_q[sb_rd].data, exp_q[sb_rd].addr, exp_q[sb_rd].data);
            end
            sb_rd++;
        end
    endtask

    task automatic test_backpressure();
        int          done_cnt = 0;
        logic [63:0] h_addr;
        logic [DW-1:0] h_data;
        @(negedge clk);
        bus.mmap = 64'h2000; bus.n = 64'd3; bus.ap_start = 1'b1;
        bus.in_valid = 1'b1; bus.wr_ready = 1'b0; auto_ack = 1'b1;
        @(negedge clk);
        bus.ap_start = 1'b0;
        @(negedge clk); #3;
        h_addr = bus.wr_addr;
        h_data = bus.wr_data;
        checks++;
        if (h_addr !== 64'h2000) begin errors++; $display("FAIL bp_first_addr: got %h want 2000", h_addr); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus.wr_valid, bus.in_ready} !== 2'b10 || bus.wr_addr !== h_addr || bus.wr_data !== h_data) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid,in_ready=%b addr=%h data=%h want 10 addr=%h data=%h",
                         k, {bus.wr_valid, bus.in_ready}, bus.wr_addr, bus.wr_data, h_addr, h_data);
            end
            @(negedge clk); #3;
        end
        @(negedge clk);
        bus.wr_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #3;
            if (bus.ap_done) done_cnt++;
            if (done_cnt > 0 && bus.ap_idle) break;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done_cnt !== 1 || writes !== 3) begin
            errors++; $display("FAIL bp_complete: got done=%0d writes=%0d want 1 and 3", done_cnt, writes);
        end
        while (sb_rd < obs_q.size()) begin
            checks++;
            if (sb_rd >= exp_q.size() || obs_q[sb_rd] !== exp_q[sb_rd]) begin
                errors++;
                $display("FAIL bp_write%0d: got addr=%h data=%h want addr=%h data=%h", sb_rd,
                         obs_q[sb_rd].addr, obs_q[sb_rd].data, exp_q[sb_rd].addr, exp_q[sb_rd].data);
            end
            sb_rd++;
        end
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL idle_err_before_ack: got %b want 0", bus.err); end
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        #3;
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL idle_ack_err: got %b want 1", bus.err); end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        @(negedge clk);
        bus.mmap = 64'h4000; bus.n = 64'd8; bus.ap_start = 1'b1;
        bus.in_valid = 1'b1; bus.wr_ready = 1'b1; auto_ack = 1'b0;
        @(negedge clk);
        bus.ap_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (writes >= 3) break;
            @(negedge clk);
        end
        checks++;
        if (writes !== 3) begin errors++; $display("FAIL rmid_three_writes: got %0d want 3", writes); end
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b0; bus.wr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if ({bus.ap_idle, bus.ap_ready, bus.ap_done, bus.in_ready, bus.wr_valid, bus.err} !== 6'b100000
            || bus.wr_addr !== 64'd0 || bus.wr_data !== '0) begin
            errors++;
            $display("FAIL rmid_reset_vals: got ctrl=%b addr=%h data=%h want 100000 0 0",
                     {bus.ap_idle, bus.ap_ready, bus.ap_done, bus.in_ready, bus.wr_valid, bus.err},
                     bus.wr_addr, bus.wr_data);
        end
        while (sb_rd < obs_q.size()) begin
            checks++;
            if (sb_rd >= exp_q.size() || obs_q[sb_rd] !== exp_q[sb_rd]) begin
                errors++;
                $display("FAIL rmid_write%0d: got addr=%h data=%h want addr=%h data=%h", sb_rd,
                         obs_q[sb_rd].addr, obs_q[sb_rd].data, exp_q[sb_rd].addr, exp_q[sb_rd].data);
            end
            sb_rd++;
        end
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            if (bus.ap_done) done_cnt++;
            @(negedge clk);
        end
        #3;
        checks++;
        if (bus.err !== 1'b1 || done_cnt !== 0) begin
            errors++; $display("FAIL rmid_late_ack: got err=%b done=%0d want err=1 done=0", bus.err, done_cnt);
        end
        @(negedge clk);
        bus.n = 64'd0; bus.ap_start = 1'b1;
        @(negedge clk);
        bus.ap_start = 1'b0;
        #3;
        checks++;
        if ({bus.err, bus.ap_done} !== 2'b01) begin
            errors++; $display("FAIL rmid_restart_clears_err: got err,done=%b want 01", {bus.err, bus.ap_done});
        end
    endtask

`ifdef S2M_OUTSTANDING_LIMIT_EN
    task automatic test_outstanding_limit();
        int done_cnt = 0;
        @(negedge clk);
        bus.mmap = 64'h8000; bus.n = 64'd6; bus.ap_start = 1'b1;
        bus.in_valid = 1'b1; bus.wr_ready = 1'b1; auto_ack = 1'b0;
        @(negedge clk);
        bus.ap_start = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        checks++;
        if (writes !== 2 || bus.in_ready !== 1'b0 || bus.wr_valid !== 1'b0) begin
            errors++; $display("FAIL cap_stall: got writes=%0d in_ready=%b wr_valid=%b want 2 0 0",
                               writes, bus.in_ready, bus.wr_valid);
        end
        @(negedge clk);
        auto_ack = 1'b1;
        #3;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL cap_ack_cycle: got in_ready=%b want 0", bus.in_ready); end
        @(negedge clk); #3;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL cap_release: got in_ready=%b want 1", bus.in_ready); end
        for (int c = 0; c < 60; c++) begin
            if (bus.ap_done) done_cnt++;
            if (done_cnt > 0 && bus.ap_idle) break;
            @(negedge clk); #3;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done_cnt !== 1 || writes !== 6) begin
            errors++; $display("FAIL cap_complete: got done=%0d writes=%0d want 1 and 6", done_cnt, writes);
        end
        while (sb_rd < obs_q.size()) begin
            checks++;
            if (sb_rd >= exp_q.size() || obs_q[sb_rd] !== exp_q[sb_rd]) begin
                errors++;
                $display("FAIL cap_write%0d: got addr=%h data=%h want addr=%h data=%h", sb_rd,
                         obs_q[sb_rd].addr, obs_q[sb_rd].data, exp_q[sb_rd].addr, exp_q[sb_rd].data);
            end
            sb_rd++;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_addr_wrap();
        test_backpressure();
        test_reset_mid();
`ifdef S2M_OUTSTANDING_LIMIT_EN
        test_outstanding_limit();
`endif
        checks++;
        if (exp_q.size() !== obs_q.size()) begin
            errors++; $display("FAIL sb_balance: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
